inst_issue_queue: RTL and testbench

- Sits directly upstream of SYSTOLIC_ARRAY and drives its `instruction` input.
- Buffers instructions pushed by a host or controller in a FIFO.
- Issues one instruction per SYSTOLIC_ARRAY `flag` pulse (rise then fall), the same slot protocol the array expects from its instruction source.
- When no instruction is queued, it fills the slot with IDLE_INST, so the array always sees a legal instruction.

---
 rtl/inst_issue_queue_pkg.sv | 33 +++
 rtl/inst_sync_fifo.sv | 54 +++++
 rtl/inst_issue_queue.sv | 96 +++++++++
 tb/tb_inst_issue_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_issue_queue_pkg.sv
// Shared instruction-format constants and issuer state encoding for the
// systolic-array instruction path (same source as the array's decoder).
package inst_issue_queue_pkg;

  localparam int INST_BITS   = 64;
  localparam int OPCODE_BITS = 4;
  localparam int OPCODE_FROM = INST_BITS - 1;
  localparam int OPCODE_TO   = INST_BITS - OPCODE_BITS;
  localparam int ADDR_BITS   = INST_BITS - OPCODE_BITS;

  localparam logic [OPCODE_BITS-1:0] IDLE_OP         = 4'd0;
  localparam logic [OPCODE_BITS-1:0] AXI_TO_UB_INST  = 4'd1;
  localparam logic [OPCODE_BITS-1:0] UB_TO_WEIGHT    = 4'd2;
  localparam logic [OPCODE_BITS-1:0] MAT_MUL_INST    = 4'd3;
  localparam logic [OPCODE_BITS-1:0] UB_TO_AXI_INST  = 4'd4;

  // Opcode zero with a zero payload is the array's no-op.
  localparam logic [INST_BITS-1:0] IDLE_INST = '0;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    SLOT_HI = 2'd1,
    SLOT_LO = 2'd2
  } issue_state_t;

  function automatic logic [INST_BITS-1:0] make_inst(
    input logic [OPCODE_BITS-1:0] op,
    input logic [ADDR_BITS-1:0]   addr
  );
    return {op, addr};
  endfunction

endpackage

// File: rtl/inst_sync_fifo.sv
// Synchronous FIFO with flush; pushes when full and pops when empty are ignored.
module inst_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign full    = (count == (PTR_BITS+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_issue_queue.sv
// Instruction issue queue feeding SYSTOLIC_ARRAY: buffers pushed instructions
// and issues one per flag pulse, filling empty slots with IDLE_INST.
module inst_issue_queue
  import inst_issue_queue_pkg::*;
#(
  parameter int INST_BITS = inst_issue_queue_pkg::INST_BITS,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INST_BITS-1:0]   in_inst,
  input  logic                   flush,
  input  logic                   flag,
  input  logic                   idle_flag,
  output logic [INST_BITS-1:0]   instruction,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_BITS-1:0]    issued_count,
  output logic                   boot_done,
  output logic                   drained,
  output issue_state_t           fsm_state
);

  localparam logic [INST_BITS-1:0] IDLE = INST_BITS'(IDLE_INST);

  // Push handshake: an entry is taken on a clock edge where in_valid and
  // in_ready are both high (and flush is low); in_ready is simply !full.
  logic                 flag_d;
  logic                 fall;
  logic                 rise;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [INST_BITS-1:0] head;

  assign fall     = flag_d & ~flag;
  assign rise     = ~flag_d & flag;
  assign in_ready = ~full;
  // A flush on the slot fall wins over the pop and the slot goes idle.
  assign pop      = (fsm_state == SLOT_LO) & fall & ~empty & ~flush;
  assign drained  = (fifo_count == '0) & (instruction == IDLE) & idle_flag;

  inst_sync_fifo #(
    .WIDTH (INST_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_inst),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_d       <= 1'b0;
      fsm_state    <= BOOT;
      instruction  <= IDLE;
      issued_count <= '0;
      boot_done    <= 1'b0;
    end else begin
      flag_d <= flag;
      unique case (fsm_state)
        BOOT: begin
          if (fall) begin
            boot_done <= 1'b1;
            fsm_state <= SLOT_HI;
          end
        end
        SLOT_HI: begin
          if (rise) fsm_state <= SLOT_LO;
        end
        SLOT_LO: begin
          if (fall) begin
            if (pop) begin
              instruction  <= head;
              issued_count <= issued_count + CNT_BITS'(1);
            end else begin
              instruction  <= IDLE;
            end
            fsm_state <= SLOT_HI;
          end
        end
        default: fsm_state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: boot, ordering, full, no-bypass,
// flush-on-fall and reset mid-slot.
module tb_inst_issue_queue;
  import inst_issue_queue_pkg::*;

  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [63:0]          in_inst;
  logic                 flush;
  logic                 flag;
  logic                 idle_flag;
  logic [63:0]          instruction;
  logic [4:0]           fifo_count;
  logic [15:0]          issued_count;
  logic                 boot_done;
  logic                 drained;
  issue_state_t         fsm_state;

  int n_vec;
  int n_err;
  logic [63:0] exp_q[$];

  inst_issue_queue #(.INST_BITS(64), .DEPTH(16), .CNT_BITS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .flush        (flush),
    .flag         (flag),
    .idle_flag    (idle_flag),
    .instruction  (instruction),
    .fifo_count   (fifo_count),
    .issued_count (issued_count),
    .boot_done    (boot_done),
    .drained      (drained),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(inst);
  endtask

  task automatic pulse_flag();
    flag = 1'b1;
    tick();
    flag = 1'b0;
    tick();
  endtask

  // one slot: expected word comes from the scoreboard queue, or IDLE if empty
  task automatic slot_check(input string tag);
    logic [63:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'h0;
    pulse_flag();
    check(tag, instruction, exp);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_inst = '0;
    flush = 1'b0;
    flag = 1'b0;
    idle_flag = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_inst", instruction, 64'h0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_issued", 64'(issued_count), 64'd0);
    check("rst_boot", 64'(boot_done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'(fsm_state), 64'(BOOT));
    check("rst_drained", 64'(drained), 64'd1);

    // boot: 3 pushes, first pulse only boots
    push(make_inst(UB_TO_WEIGHT, 60'h111));
    push(make_inst(UB_TO_WEIGHT, 60'h222));
    push(make_inst(UB_TO_AXI_INST, 60'h333));
    check("boot_count3", 64'(fifo_count), 64'd3);
    pulse_flag();
    check("boot_inst_idle", instruction, 64'h0);
    check("boot_done", 64'(boot_done), 64'd1);
    check("boot_count_kept", 64'(fifo_count), 64'd3);
    check("boot_state", 64'(fsm_state), 64'(SLOT_HI));
    pulse_flag();
    check("boot_first", instruction, 64'h2000_0000_0000_0111);
    void'(exp_q.pop_front());
    check("boot_issued1", 64'(issued_count), 64'd1);
    for (int i = 0; i < 2; i++) slot_check("boot_rest");
    slot_check("boot_idle");
    check("boot_issued3", 64'(issued_count), 64'd3);
    idle_flag = 1'b0;
    #1;
    check("drained_busy", 64'(drained), 64'd0);
    idle_flag = 1'b1;
    #1;
    check("drained_idle", 64'(drained), 64'd1);

    // ordering: MAT_MUL addr 0..7
    for (int i = 0; i < 8; i++) push(make_inst(MAT_MUL_INST, 60'(i)));
    check("ord_drained_0", 64'(drained), 64'd0);
    for (int i = 0; i < 8; i++) slot_check("ord_seq");
    check("ord_last", instruction, 64'h3000_0000_0000_0007);
    check("ord_issued", 64'(issued_count), 64'd11);
    slot_check("ord_idle");
    check("ord_drained", 64'(drained), 64'd1);

    // full: 17 pushes, 17th dropped
    for (int i = 0; i < 16; i++) push(make_inst(AXI_TO_UB_INST, 60'(i + 16'h100)));
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(fifo_count), 64'd16);
    in_valid = 1'b1;
    in_inst  = make_inst(AXI_TO_UB_INST, 60'hdead);
    tick();
    in_valid = 1'b0;
    check("full_drop_count", 64'(fifo_count), 64'd16);
    slot_check("full_head");
    check("full_head_val", instruction, 64'h1000_0000_0000_0100);
    check("full_ready_again", 64'(in_ready), 64'd1);
    for (int i = 0; i < 15; i++) slot_check("full_seq");
    slot_check("full_no17");
    check("full_issued", 64'(issued_count), 64'd27);

    // no bypass: push on the fall cycle with empty FIFO
    flag = 1'b1;
    tick();
    flag = 1'b0;
    in_valid = 1'b1;
    in_inst  = make_inst(MAT_MUL_INST, 60'hbeef);
    tick();
    in_valid = 1'b0;
    check("nb_idle", instruction, 64'h0);
    check("nb_count", 64'(fifo_count), 64'd1);
    check("nb_issued", 64'(issued_count), 64'd27);
    pulse_flag();
    check("nb_next", instruction, 64'h3000_0000_0000_beef);
    check("nb_issued1", 64'(issued_count), 64'd28);

    // flush on the fall, with a push in the same cycle
    for (int i = 0; i < 5; i++) push(make_inst(UB_TO_AXI_INST, 60'(i)));
    exp_q.delete();
    check("fl_count5", 64'(fifo_count), 64'd5);
    flag = 1'b1;
    tick();
    flag = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    in_inst = make_inst(MAT_MUL_INST, 60'h55);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_idle", instruction, 64'h0);
    check("fl_count0", 64'(fifo_count), 64'd0);
    check("fl_issued", 64'(issued_count), 64'd28);
    slot_check("fl_after");

    // reset mid-slot with 4 queued and a live instruction
    for (int i = 0; i < 5; i++) push(make_inst(MAT_MUL_INST, 60'(i + 16'h40)));
    slot_check("rm_first");
    flag = 1'b1;
    tick();
    check("rm_state_lo", 64'(fsm_state), 64'(SLOT_LO));
    check("rm_count4", 64'(fifo_count), 64'd4);
    #2;
    reset = 1'b1;
    #1;
    check("rm_inst", instruction, 64'h0);
    check("rm_count", 64'(fifo_count), 64'd0);
    check("rm_boot", 64'(boot_done), 64'd0);
    check("rm_issued", 64'(issued_count), 64'd0);
    exp_q.delete();
    flag = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    push(make_inst(MAT_MUL_INST, 60'h77));
    pulse_flag();
    check("rm_reboot_idle", instruction, 64'h0);
    check("rm_reboot_done", 64'(boot_done), 64'd1);
    slot_check("rm_after_boot");
    check("rm_issued1", 64'(issued_count), 64'd1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
